// File: rtl/match_collector.sv
// Packs one frame of detector match flags into a parallel result word with count/length fields.
// Optional MATCH_COLLECTOR_POS_EN adds first/last match position outputs.
module match_collector #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             match_in,
  input  logic             frame_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_len,
  output logic             out_ovf,
`ifdef MATCH_COLLECTOR_POS_EN
  output logic [IDX_W-1:0] out_first_pos,
  output logic [IDX_W-1:0] out_last_pos,
`endif
  output logic [1:0]       dbg_state
);

  // Handshake: a flag moves when bit_valid && in_ready; a result moves when
  // out_valid && out_ready. Neither valid may depend on its ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic             ovf;
  logic [IDX_W-1:0] slot;
  logic             last_slot;
  logic             accept;
  logic             close;
  logic             close_ovf;
  logic             transfer;

  // slot is the frame-order index of the flag being accepted now
  assign slot      = IDX_W'(len);
  assign last_slot = (slot == IDX_W'(WIDTH - 1)) && (len < CNT_W'(WIDTH));
  assign accept    = bit_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign close     = accept && (frame_last || last_slot);
  assign close_ovf = accept && !frame_last && last_slot;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign out_word  = shreg;
  assign out_count = cnt;
  assign out_len   = len;
  assign out_ovf   = ovf;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COLLECT: begin
        if (close)       state_next = HOLD;
        else if (accept) state_next = COLLECT;
      end
      HOLD: begin
        if (transfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || transfer) begin
      shreg <= '0;
      cnt   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      shreg <= {shreg[WIDTH-2:0], match_in};
      cnt   <= cnt + CNT_W'(match_in);
      len   <= len + CNT_W'(1);
      ovf   <= close_ovf;
    end
  end

`ifdef MATCH_COLLECTOR_POS_EN
  logic [IDX_W-1:0] first_pos;
  logic [IDX_W-1:0] last_pos;

  assign out_first_pos = first_pos;
  assign out_last_pos  = last_pos;

  always_ff @(posedge clk) begin
    if (reset || transfer) begin
      first_pos <= '0;
      last_pos  <= '0;
    end else if (accept && match_in) begin
      if (cnt == '0) first_pos <= slot;
      last_pos <= slot;
    end
  end
`endif

endmodule

// File: doc/match_collector.md
Name: match_collector

Overview:
- Downstream stage of the serial pattern detector: consumes one match flag per accepted bit and packs a frame of flags into a parallel result word with match count and frame length.
- Presents each completed frame on a valid/ready output port; stalls the detector through in_ready while a result is held.
- Sits between the detector and the register/readout logic that prints or stores the detection string.

Parameters:
- WIDTH, 16, maximum flags per frame and width of out_word.
- CNT_W, $clog2(WIDTH+1), width of the count and length fields (5 at default).
- IDX_W, $clog2(WIDTH), width of the position fields (4 at default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- bit_valid  input  1  match_in is valid this cycle.
- match_in  input  1  detector flag for the current bit (1 = pattern completed on this bit).
- frame_last  input  1  qualifies with bit_valid: this bit ends the frame.
- in_ready  output  1  collector accepts a flag this cycle.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- out_word  output  WIDTH  packed flags; the earliest flag is at bit out_len-1 and the last flag at bit 0.
- out_count  output  CNT_W  number of 1 flags in the frame.
- out_len  output  CNT_W  number of flags in the frame, 1..WIDTH.
- out_ovf  output  1  frame was force-closed at WIDTH flags without frame_last.

Behaviour:
- Reset is synchronous and active-high. While reset=1 at a clock edge:
  - state goes to IDLE;
  - out_valid=0, out_word=0, out_count=0, out_len=0, out_ovf=0;
  - internal accumulators are cleared.
  - A reset mid-frame or during HOLD discards the partial frame or the pending result; nothing is emitted.
- A flag is accepted when bit_valid && in_ready. in_ready=1 in IDLE and COLLECT, and 0 in HOLD.
- Accept action:
  - shift register <= {shreg[WIDTH-2:0], match_in};
  - cnt += match_in;
  - len += 1.
- FSM states:
  - IDLE: accumulators are zero.
    - On accept with frame_last=1, go to HOLD.
    - On accept with frame_last=0, go to COLLECT.
    - With no accept, stay in IDLE.
  - COLLECT:
    - On accept with frame_last=1, go to HOLD.
    - On accept where the new len equals WIDTH and frame_last=0, go to HOLD with out_ovf=1.
    - Otherwise stay in COLLECT.
  - HOLD:
    - out_valid=1. All out_* fields are registered and stable until the transfer.
    - On out_valid && out_ready, go to IDLE: out_valid drops and accumulators clear on the same edge.
- Latency:
  - If the final flag is accepted at edge N, out_valid=1 after edge N, and the fields already include that flag.
  - The earliest next-frame accept is the cycle after the transfer edge, so HOLD lasts at least 1 cycle.
- Width rules:
  - Unused upper bits of out_word are 0 when out_len < WIDTH.
  - out_count <= out_len always holds.
  - Counters never wrap, because the frame closes at WIDTH.
- frame_last at exactly the WIDTH-th flag is a normal close with out_ovf=0.
- bit_valid while in_ready=0 is ignored; the upstream stage must hold its data.
- When bit_valid=0, frame_last is ignored.

Optional Feature:
- Macro: MATCH_COLLECTOR_POS_EN.
- Defined:
  - Adds outputs out_first_pos and out_last_pos, each IDX_W wide and registered with the other fields.
  - They hold the 0-based frame-order index of the first and last 1 flag (index 0 = first flag of the frame).
  - Both are 0 when out_count=0.
  - Both reset to 0.
- Not defined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 15 flags 0,0,0,1,0,0,0,0,0,1,0,0,0,0,1 with frame_last on the 15th and out_ready=1 -> out_valid one cycle after the last accept, out_word=16'h0821, out_count=3, out_len=15, out_ovf=0; with POS_EN, first_pos=3 and last_pos=14.
- 16 flags all 1 with no frame_last -> out_word=16'hFFFF, out_count=16, out_len=16, out_ovf=1; a 17th bit_valid during HOLD is not accepted (in_ready=0).
- Hold out_ready=0 for 5 cycles after a frame {1,0,1} with last -> out_valid stays 1, out_word=16'h0005, out_count=2, out_len=3 unchanged each cycle, in_ready=0; transfer on the 6th cycle, then in_ready=1.
- Single-flag frame match_in=0 with frame_last=1 from IDLE -> out_word=0, out_count=0, out_len=1; with POS_EN, both positions are 0.
- Assert reset for 1 cycle after 7 flags of a frame -> all outputs 0, state IDLE; a new 2-flag frame {1,1} yields out_word=16'h0003, out_len=2, with no residue from the aborted frame.
- Back-to-back frames with out_ready=1 and bit_valid held 1 -> exactly one idle accept cycle (the HOLD cycle) between frames, and the second frame's fields are independent of the first.
